// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared defaults, derived widths and word type for the synchronous FIFO
package fifo_pkg;

  localparam int DEF_FIFO_WIDTH = 16;
  localparam int DEF_FIFO_DEPTH = 8;

  // Widths derived from the default geometry; count needs one extra bit to hold FIFO_DEPTH.
  localparam int PTR_W = $clog2(DEF_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [DEF_FIFO_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - FIFO storage: register array, one write port, one registered read port
module fifo_mem
  import fifo_pkg::*;
#(
  parameter  int WIDTH = DEF_FIFO_WIDTH,
  parameter  int DEPTH = DEF_FIFO_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array is deliberately left out of reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port: holds its last value when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem_q[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock FIFO with status flags; FIFO_SVA_EN enables embedded assertions/covers
module fifo_sync
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = DEF_FIFO_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty
);

  localparam int PTR_WIDTH = $clog2(FIFO_DEPTH);
  localparam int CNT_WIDTH = PTR_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_FULL  = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_AFULL = CNT_WIDTH'(FIFO_DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE   = PTR_WIDTH'(1);

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic                 wr_ack_q, overflow_q, underflow_q;
  logic                 wr_ok, rd_ok;

  // Flags come straight from occupancy so they follow reset without a clock edge.
  assign full        = (count_q == CNT_FULL);
  assign almostfull  = (count_q == CNT_AFULL);
  assign empty       = (count_q == '0);
  assign almostempty = (count_q == CNT_ONE);

  // A write is blocked only by full, a read only by empty; both together resolve naturally.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  // Next-state for pointers and occupancy; pointers wrap by natural overflow of their width.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_ok) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_ok, rd_ok})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Pointer/count state plus the one-cycle handshake and error pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      wr_ack_q    <= wr_ok;
      overflow_q  <= wr_en && full;
      underflow_q <= rd_en && empty;
    end
  end

  assign wr_ack    = wr_ack_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (wr_ok),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (data_in),
    .rd_en_i   (rd_ok),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (data_out)
  );

`ifdef FIFO_SVA_EN
  a_count_range: assert property (@(posedge clk) disable iff (!rst_n) count_q <= CNT_FULL);
  a_flags_excl:  assert property (@(posedge clk) disable iff (!rst_n) !(full && empty));
  a_full_cnt:    assert property (@(posedge clk) disable iff (!rst_n) full == (count_q == CNT_FULL));
  a_empty_cnt:   assert property (@(posedge clk) disable iff (!rst_n) empty == (count_q == '0));
  a_wr_ack_set:  assert property (@(posedge clk) disable iff (!rst_n) wr_ok |=> wr_ack);
  a_wr_ack_clr:  assert property (@(posedge clk) disable iff (!rst_n) !wr_ok |=> !wr_ack);
  a_ovf_set:     assert property (@(posedge clk) disable iff (!rst_n) (wr_en && full) |=> overflow);
  a_ovf_clr:     assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full) |=> !overflow);
  a_udf_set:     assert property (@(posedge clk) disable iff (!rst_n) (rd_en && empty) |=> underflow);
  a_udf_clr:     assert property (@(posedge clk) disable iff (!rst_n) !(rd_en && empty) |=> !underflow);
  a_wr_wrap:     assert property (@(posedge clk) disable iff (!rst_n)
                   (wr_ok && wr_ptr_q == PTR_WIDTH'(FIFO_DEPTH - 1)) |=> (wr_ptr_q == '0));
  a_rd_wrap:     assert property (@(posedge clk) disable iff (!rst_n)
                   (rd_ok && rd_ptr_q == PTR_WIDTH'(FIFO_DEPTH - 1)) |=> (rd_ptr_q == '0));

  c_full:        cover property (@(posedge clk) disable iff (!rst_n) full);
  c_empty:       cover property (@(posedge clk) disable iff (!rst_n) empty);
  c_almostfull:  cover property (@(posedge clk) disable iff (!rst_n) almostfull);
  c_almostempty: cover property (@(posedge clk) disable iff (!rst_n) almostempty);
  c_wr_ack:      cover property (@(posedge clk) disable iff (!rst_n) wr_ack);
  c_overflow:    cover property (@(posedge clk) disable iff (!rst_n) overflow);
  c_underflow:   cover property (@(posedge clk) disable iff (!rst_n) underflow);
`endif

endmodule

// File: tb/tb_fifo_sync.sv
// tb/tb_fifo_sync.sv - directed self-checking bench for fifo_sync
module tb_fifo_sync;

  logic        clk;
  logic        rst_n;
  logic [15:0] data_in;
  logic        wr_en;
  logic        rd_en;
  logic [15:0] data_out;
  logic        wr_ack, overflow, underflow;
  logic        full, empty, almostfull, almostempty;

  int checks;
  int failures;

  fifo_sync #(
    .FIFO_WIDTH (16),
    .FIFO_DEPTH (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .data_in     (data_in),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .data_out    (data_out),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almostfull  (almostfull),
    .almostempty (almostempty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%b exp=1", empty); end
    checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
    checks++; if (almostfull !== 1'b0 || almostempty !== 1'b0) begin failures++; $display("FAIL reset_almost got=%b%b exp=00", almostfull, almostempty); end
    checks++; if (data_out !== 16'h0000) begin failures++; $display("FAIL reset_data_out got=%h exp=0000", data_out); end
    checks++; if ({wr_ack, overflow, underflow} !== 3'b000) begin failures++; $display("FAIL reset_pulses got=%b exp=000", {wr_ack, overflow, underflow}); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1 || wr_ack !== 1'b0 || data_out !== 16'h0000) begin failures++; $display("FAIL idle_after_reset got empty=%b wr_ack=%b data=%h exp 1 0 0000", empty, wr_ack, data_out); end
  endtask

  task automatic test_fill();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); wr_en = 1'b1; data_in = 16'(i);
      @(posedge clk); #1;
      checks++; if (wr_ack !== 1'b1) begin failures++; $display("FAIL fill_wr_ack[%0d] got=%b exp=1", i, wr_ack); end
      checks++; if (almostfull !== (i == 7)) begin failures++; $display("FAIL fill_almostfull[%0d] got=%b exp=%b", i, almostfull, (i == 7)); end
      checks++; if (full !== (i == 8)) begin failures++; $display("FAIL fill_full[%0d] got=%b exp=%b", i, full, (i == 8)); end
      checks++; if (almostempty !== (i == 1) || empty !== 1'b0) begin failures++; $display("FAIL fill_low_flags[%0d] got ae=%b e=%b", i, almostempty, empty); end
    end
    @(negedge clk); wr_en = 1'b0;
  endtask

  task automatic test_overflow();
    @(negedge clk); wr_en = 1'b1; data_in = 16'hDEAD;
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_overflow got=%b exp=1", overflow); end
    checks++; if (wr_ack !== 1'b0) begin failures++; $display("FAIL ovf_wr_ack got=%b exp=0", wr_ack); end
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
    @(negedge clk); wr_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
  endtask

  task automatic test_drain();
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk); rd_en = 1'b1;
      @(posedge clk); #1;
      checks++; if (data_out !== 16'(i)) begin failures++; $display("FAIL drain_data[%0d] got=%h exp=%h", i, data_out, 16'(i)); end
      checks++; if (almostempty !== (i == 7)) begin failures++; $display("FAIL drain_almostempty[%0d] got=%b exp=%b", i, almostempty, (i == 7)); end
      checks++; if (empty !== (i == 8)) begin failures++; $display("FAIL drain_empty[%0d] got=%b exp=%b", i, empty, (i == 8)); end
      checks++; if (almostfull !== (i == 1) || full !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL drain_flags[%0d] got af=%b f=%b u=%b", i, almostfull, full, underflow); end
    end
    @(negedge clk); rd_en = 1'b0;
  endtask

  task automatic test_underflow();
    @(negedge clk); rd_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL udf_underflow got=%b exp=1", underflow); end
    checks++; if (data_out !== 16'h0008) begin failures++; $display("FAIL udf_data_held got=%h exp=0008", data_out); end
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL udf_empty got=%b exp=1", empty); end
    @(negedge clk); rd_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL udf_clear got=%b exp=0", underflow); end
  endtask

  task automatic test_simultaneous();
    // Both at empty: write only.
    @(negedge clk); wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h00AA;
    @(posedge clk); #1;
    checks++; if (wr_ack !== 1'b1 || underflow !== 1'b1) begin failures++; $display("FAIL simul_empty_pulses got ack=%b udf=%b exp 1 1", wr_ack, underflow); end
    checks++; if (almostempty !== 1'b1 || empty !== 1'b0) begin failures++; $display("FAIL simul_empty_count got ae=%b e=%b exp 1 0", almostempty, empty); end
    checks++; if (data_out !== 16'h0008) begin failures++; $display("FAIL simul_empty_data got=%h exp=0008", data_out); end
    // Top up to full.
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); wr_en = 1'b1; rd_en = 1'b0; data_in = 16'h00B0 + 16'(i);
      @(posedge clk);
    end
    #1;
    checks++; if (full !== 1'b1) begin failures++; $display("FAIL simul_topup_full got=%b exp=1", full); end
    // Both at full: read only.
    @(negedge clk); wr_en = 1'b1; rd_en = 1'b1; data_in = 16'hBEEF;
    @(posedge clk); #1;
    checks++; if (overflow !== 1'b1 || wr_ack !== 1'b0) begin failures++; $display("FAIL simul_full_pulses got ovf=%b ack=%b exp 1 0", overflow, wr_ack); end
    checks++; if (data_out !== 16'h00AA) begin failures++; $display("FAIL simul_full_data got=%h exp=00aa", data_out); end
    checks++; if (almostfull !== 1'b1 || full !== 1'b0) begin failures++; $display("FAIL simul_full_count got af=%b f=%b exp 1 0", almostfull, full); end
    // Remaining entries must exclude 0xBEEF.
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk); wr_en = 1'b0; rd_en = 1'b1;
      @(posedge clk); #1;
      checks++; if (data_out !== 16'h00B0 + 16'(i)) begin failures++; $display("FAIL simul_drain[%0d] got=%h exp=%h", i, data_out, 16'h00B0 + 16'(i)); end
    end
    @(negedge clk); rd_en = 1'b0;
    @(posedge clk); #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL simul_end_empty got=%b exp=1", empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); wr_en = 1'b1; data_in = 16'h0100 + 16'(i);
      @(posedge clk);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); wr_en = 1'b1; rd_en = 1'b1; data_in = 16'h0104 + 16'(k);
      @(posedge clk); #1;
      checks++; if (data_out !== 16'h0100 + 16'(k)) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", k, data_out, 16'h0100 + 16'(k)); end
      checks++; if (dut.count_q !== 4'd4) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=4", k, dut.count_q); end
      checks++; if (wr_ack !== 1'b1 || overflow !== 1'b0 || underflow !== 1'b0) begin failures++; $display("FAIL b2b_pulses[%0d] got ack=%b ovf=%b udf=%b exp 1 0 0", k, wr_ack, overflow, underflow); end
    end
    @(negedge clk); wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(negedge clk); wr_en = 1'b1; data_in = 16'h0555;
    @(posedge clk); #1;
    checks++; if (dut.count_q !== 4'd5) begin failures++; $display("FAIL rstmid_count got=%0d exp=5", dut.count_q); end
    @(negedge clk); wr_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL rstmid_empty got=%b exp=1", empty); end
    checks++; if (almostempty !== 1'b0 || full !== 1'b0 || almostfull !== 1'b0) begin failures++; $display("FAIL rstmid_flags got ae=%b f=%b af=%b exp 0 0 0", almostempty, full, almostfull); end
    checks++; if (data_out !== 16'h0000 || wr_ack !== 1'b0) begin failures++; $display("FAIL rstmid_outputs got data=%h ack=%b exp 0000 0", data_out, wr_ack); end
    @(negedge clk); rst_n = 1'b1; rd_en = 1'b1;
    @(posedge clk); #1;
    checks++; if (underflow !== 1'b1 || data_out !== 16'h0000) begin failures++; $display("FAIL rstmid_discarded got udf=%b data=%h exp 1 0000", underflow, data_out); end
    @(negedge clk); rd_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    data_in  = 16'h0000;
    test_reset();
    test_fill();
    test_overflow();
    test_drain();
    test_underflow();
    test_simultaneous();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
